// File: rtl/dino_pkg.sv
// Shared types and constants for the ground scroller.
// Holds the FSM encodings, the LFSR taps and seed, and the LFSR step function.
package dino_pkg;

  localparam int GROUND_W = 320;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } scroll_state_t;

  typedef enum logic {
    FLAT = 1'b0,
    BUMP = 1'b1
  } gen_state_t;

  // Taps at bits 15,13,12,10: x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ground_lfsr.sv
// 16-bit Fibonacci LFSR that steps once per cycle while en is high.
// Reset loads SEED, which must be non-zero.
module ground_lfsr
  import dino_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        vga_clk,
  input  logic        clrn,
  input  logic        en,
  output logic [15:0] q
);

  always_ff @(posedge vga_clk) begin
    if (!clrn) begin
      q <= SEED;
    end else if (en) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/ground_scroller.sv
// Scrolls the ground bitmap left by `speed` pixels after each rising edge of vs,
// feeding new pixels from an LFSR-driven flat/bump generator and counting distance.
module ground_scroller
  import dino_pkg::*;
#(
  parameter int          W        = GROUND_W,
  parameter int          SPEED_W  = 4,
  parameter int          MIN_FLAT = 8,
  parameter logic [15:0] SEED     = LFSR_SEED
) (
  input  logic               vga_clk,
  input  logic               clrn,
  input  logic               run,
  input  logic               clear,
  input  logic [SPEED_W-1:0] speed,
  input  logic               vs,
  output logic [W-1:0]       px_ground,
  output logic [15:0]        distance,
  output logic               busy
);

  logic               vs_d1, vs_d2;
  logic               tick;
  scroll_state_t      state, state_nx;
  logic [SPEED_W-1:0] rem, rem_nx;
  logic               shift;
  gen_state_t         gen, gen_nx;
  logic [8:0]         cnt, cnt_nx;
  logic [15:0]        lfsr_q;

  assign tick = vs_d1 & ~vs_d2;
  assign busy = (state == SHIFT);

  ground_lfsr #(.SEED(SEED)) u_lfsr (
    .vga_clk (vga_clk),
    .clrn    (clrn),
    .en      (shift),
    .q       (lfsr_q)
  );

  // Scroll sequencer: a dropped run aborts the burst without shifting.
  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    shift    = 1'b0;
    if (clear) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (tick && run && (speed != '0)) begin
            state_nx = SHIFT;
            rem_nx   = speed;
          end
        end
        SHIFT: begin
          if (!run) begin
            state_nx = IDLE;
          end else begin
            shift  = 1'b1;
            rem_nx = rem - SPEED_W'(1);
            if (rem == SPEED_W'(1)) begin
              state_nx = IDLE;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Run lengths are drawn from the LFSR value before it advances on this shift.
  always_comb begin
    gen_nx = gen;
    cnt_nx = cnt;
    if (clear) begin
      gen_nx = FLAT;
      cnt_nx = 9'(MIN_FLAT);
    end else if (shift) begin
      if (cnt == 9'd1) begin
        if (gen == BUMP) begin
          gen_nx = FLAT;
          cnt_nx = 9'(MIN_FLAT) + {4'b0, lfsr_q[4:0]};
        end else begin
          gen_nx = BUMP;
          cnt_nx = 9'd1 + {7'b0, lfsr_q[1:0]};
        end
      end else begin
        cnt_nx = cnt - 9'd1;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!clrn) begin
      vs_d1     <= 1'b1;
      vs_d2     <= 1'b1;
      state     <= IDLE;
      rem       <= '0;
      gen       <= FLAT;
      cnt       <= 9'(MIN_FLAT);
      px_ground <= '0;
      distance  <= '0;
    end else begin
      vs_d1 <= vs;
      vs_d2 <= vs_d1;
      state <= state_nx;
      rem   <= rem_nx;
      gen   <= gen_nx;
      cnt   <= cnt_nx;
      if (clear) begin
        px_ground <= '0;
        distance  <= '0;
      end else if (shift) begin
        px_ground <= {(gen == BUMP), px_ground[W-1:1]};
        if (distance != 16'hFFFF) begin
          distance <= distance + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ground_scroller.sv
// Directed bench for ground_scroller with an independent bitmap/generator model.
module tb_ground_scroller;

  logic         vga_clk = 1'b0;
  logic         clrn, run, clear, vs;
  logic [3:0]   speed;
  logic [319:0] px_ground;
  logic [15:0]  distance;
  logic         busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [319:0] m_px;
  logic [15:0]  m_dist;
  logic [15:0]  m_lfsr;
  logic         m_bump;
  int           m_cnt;

  always #5 vga_clk = ~vga_clk;

  ground_scroller dut (
    .vga_clk   (vga_clk),
    .clrn      (clrn),
    .run       (run),
    .clear     (clear),
    .speed     (speed),
    .vs        (vs),
    .px_ground (px_ground),
    .distance  (distance),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_shift();
    logic fb;
    m_px = {m_bump, m_px[319:1]};
    if (m_dist != 16'hFFFF) m_dist = m_dist + 16'd1;
    if (m_cnt == 1) begin
      if (m_bump) begin
        m_bump = 1'b0;
        m_cnt  = 8 + int'(m_lfsr[4:0]);
      end else begin
        m_bump = 1'b1;
        m_cnt  = 1 + int'(m_lfsr[1:0]);
      end
    end else begin
      m_cnt = m_cnt - 1;
    end
    fb     = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
    m_lfsr = {m_lfsr[14:0], fb};
  endtask

  task automatic model_clear();
    m_px   = '0;
    m_dist = '0;
    m_bump = 1'b0;
    m_cnt  = 8;
  endtask

  // One vs rising edge, then watch busy for a bounded window.
  task automatic frame(input int exp_shifts, input string tag);
    int first;
    int nbusy;
    vs = 1'b0;
    repeat (2) @(negedge vga_clk);
    vs    = 1'b1;
    first = -1;
    nbusy = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge vga_clk);
      if (busy === 1'b1) begin
        if (first < 0) first = i;
        nbusy++;
      end
    end
    for (int k = 0; k < exp_shifts; k++) model_shift();
    chk({tag, "_busy_cycles"}, 320'(nbusy), 320'(exp_shifts));
    if (exp_shifts > 0) chk({tag, "_busy_start"}, 320'(first), 320'(2));
    chk({tag, "_px"}, px_ground, m_px);
    chk({tag, "_dist"}, 320'(distance), 320'(m_dist));
  endtask

  initial begin
    int nbusy;
    m_lfsr = 16'hACE1;
    model_clear();

    // 1. Reset with vs toggling, then release with vs high.
    clrn = 1'b0; run = 1'b0; clear = 1'b0; speed = 4'd0; vs = 1'b0;
    @(negedge vga_clk); vs = 1'b1;
    @(negedge vga_clk); vs = 1'b0;
    @(negedge vga_clk);
    chk("reset_px", px_ground, '0);
    chk("reset_dist", 320'(distance), 320'(0));
    chk("reset_busy", 320'(busy), 320'(0));
    vs = 1'b1; run = 1'b1; speed = 4'd3;
    @(negedge vga_clk);
    clrn  = 1'b1;
    nbusy = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge vga_clk);
      if (busy !== 1'b0) nbusy++;
    end
    chk("post_reset_no_burst", 320'(nbusy), 320'(0));
    chk("post_reset_dist", 320'(distance), 320'(0));

    // 2. Basic scroll of 3 flat pixels.
    frame(3, "basic");
    chk("basic_top3", 320'(px_ground[319:317]), 320'(0));

    // 3. Generator over 60 more shifts (63 total).
    speed = 4'd15;
    for (int f = 0; f < 4; f++) frame(15, "gen");
    chk("gen_first_flat", 320'(px_ground[264:257]), 320'(0));
    chk("gen_first_bump", 320'(px_ground[265]), 320'(1));

    // 4. Gating: speed 0, then run low.
    speed = 4'd0;
    frame(0, "speed0");
    run = 1'b0; speed = 4'd5;
    frame(0, "run0");
    run = 1'b1;

    // 5. Abort after the 4th shift, then a fresh burst of 10.
    speed = 4'd10;
    vs = 1'b0;
    repeat (2) @(negedge vga_clk);
    vs = 1'b1;
    repeat (6) @(negedge vga_clk);
    run = 1'b0;
    @(negedge vga_clk);
    for (int k = 0; k < 4; k++) model_shift();
    chk("abort_busy", 320'(busy), 320'(0));
    chk("abort_dist", 320'(distance), 320'(m_dist));
    repeat (4) @(negedge vga_clk);
    chk("abort_px_hold", px_ground, m_px);
    chk("abort_dist_hold", 320'(distance), 320'(m_dist));
    run = 1'b1;
    frame(10, "after_abort");

    // 6. Saturation from a preloaded distance.
    force dut.distance = 16'hFFEC;
    @(negedge vga_clk);
    release dut.distance;
    m_dist = 16'hFFEC;
    @(negedge vga_clk);
    chk("preload_dist", 320'(distance), 320'(16'hFFEC));
    speed = 4'd15;
    frame(15, "sat_a");
    speed = 4'd5;
    frame(5, "sat_b");
    chk("sat_value", 320'(distance), 320'(16'hFFFF));

    // Clear mid-burst: two shifts land, then clear.
    speed = 4'd10;
    vs = 1'b0;
    repeat (2) @(negedge vga_clk);
    vs = 1'b1;
    repeat (4) @(negedge vga_clk);
    clear = 1'b1;
    @(negedge vga_clk);
    for (int k = 0; k < 2; k++) model_shift();
    model_clear();
    chk("clear_px", px_ground, '0);
    chk("clear_dist", 320'(distance), 320'(0));
    chk("clear_busy", 320'(busy), 320'(0));
    clear = 1'b0;

    // Tick coinciding with clear: no burst.
    vs = 1'b0;
    repeat (2) @(negedge vga_clk);
    vs = 1'b1;
    @(negedge vga_clk);
    clear = 1'b1;
    @(negedge vga_clk);
    clear = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge vga_clk);
      if (busy !== 1'b0) nbusy++;
    end
    chk("tick_clear_no_burst", 320'(nbusy), 320'(0));

    // LFSR survives clear; generator restarts flat.
    speed = 4'd12;
    frame(12, "post_clear");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ground_scroller.md
Name: ground_scroller

Overview:
- Upstream producer of the 320-bit ground-line bitmap `px_ground` that the Vga display block draws.
- Once per video frame, during vertical sync, it scrolls the ground left by a programmable number of pixels.
- New pixels enter at the right edge. An LFSR-driven flat/bump generator creates them.
- It also keeps a distance counter used for game scoring.

Parameters:
- W, 320, ground line width in pixels; equals px_ground width.
- SPEED_W, 4, width of the speed input.
- MIN_FLAT, 8, minimum flat run length in pixels (1..255).
- SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- vga_clk  in  1  single clock; same clock as Vga.
- clrn  in  1  reset, synchronous, active-low.
- run  in  1  game running; when low, frame ticks are ignored.
- clear  in  1  synchronous game restart.
- speed  in  SPEED_W  pixels to scroll per frame.
- vs  in  1  vertical sync from Vga.
- px_ground  out  W  ground bitmap; bit 0 = leftmost column; 1 = ground-texture pixel.
- distance  out  16  total pixels scrolled; saturates at 16'hFFFF.
- busy  out  1  high while the scroll burst is in progress.

Behaviour:
- Reset (clrn=0 at a vga_clk edge):
  - px_ground=0, distance=0, busy=0.
  - Scroll FSM = IDLE.
  - Generator = FLAT with cnt=MIN_FLAT.
  - lfsr=SEED.
  - vs_d1=vs_d2=1, so no spurious tick after reset.
- Frame tick:
  - vs is registered twice (vs_d1, vs_d2).
  - tick = vs_d1 & ~vs_d2, i.e. a rising edge of vs.
  - tick is high for exactly one cycle per rising edge.
- Scroll FSM:
  - IDLE: on tick with run=1 and speed!=0, load rem=speed and go to SHIFT. Otherwise stay in IDLE; this covers speed=0 and run=0.
  - SHIFT: perform one pixel shift per cycle and decrement rem. When rem reaches 1 and the shift is done, return to IDLE.
  - busy = (state==SHIFT).
  - Ticks arriving while in SHIFT are ignored.
  - run falling while in SHIFT: no shift in that cycle. The FSM goes to IDLE and the remaining shifts are dropped.
- Latency:
  - vs rises before edge N; vs_d1=1 after edge N.
  - FSM loads at edge N+1.
  - The first shift is visible after edge N+2.
  - The last shift is visible after edge N+1+speed.
- One shift (single cycle):
  - px_ground <= {new_bit, px_ground[W-1:1]}.
  - new_bit = (gen==BUMP).
  - distance <= distance+1, saturating.
  - lfsr advances one step.
- LFSR:
  - 16-bit Fibonacci, x^16+x^14+x^13+x^11+1.
  - feedback = l[15]^l[13]^l[12]^l[10]; next = {l[14:0], feedback}.
  - Advances only on shifts.
- Generator (updates only on shifts, after new_bit is emitted for the current state):
  - If cnt==1, toggle state and reload cnt:
    - entering FLAT: cnt = MIN_FLAT + lfsr[4:0].
    - entering BUMP: cnt = 1 + lfsr[1:0].
    - Both use the pre-advance lfsr value.
  - Otherwise cnt-1.
  - cnt is 9 bits wide.
- clear=1 (priority below clrn, above everything else):
  - px_ground=0, distance=0, FSM=IDLE.
  - Generator = FLAT with cnt=MIN_FLAT.
  - lfsr is NOT reset, so each game differs.
  - vs registers keep sampling normally.
- Simultaneous tick and clear: clear wins; no burst starts.

Decomposition:
- Package dino_pkg holds:
  - GROUND_W=320.
  - Scroll FSM encodings: IDLE, SHIFT.
  - Generator encodings: FLAT, BUMP.
  - LFSR tap constant and default seed.
- Sub-module ground_lfsr: 16-bit LFSR with ports vga_clk, clrn, en, q[15:0], parameter SEED.
- All remaining logic stays in ground_scroller.

Test Plan:
1. Reset: clrn=0 for 2 cycles with vs toggling -> px_ground=0, distance=0, busy=0. After release with vs held at 1, no burst occurs.
2. Basic scroll: run=1, speed=3, one vs 0->1 -> busy high exactly 3 cycles starting 2 edges after vs_d1 sets. distance=3. px_ground[319:317]=0 (flat). Remaining bits still 0.
3. Generator: run=1, speed=15, 4 frames (60 shifts) -> first 8 new bits are 0, then a bump of 1+lfsr[1:0] ones, then flat of MIN_FLAT+lfsr[4:0]. The bench checks px_ground bit-exact against a reference model seeded with 16'hACE1.
4. Gating: speed=0 with a tick, and run=0 with speed=5 and a tick -> no change to px_ground or distance; busy stays 0.
5. Abort: speed=10, drop run after the 4th shift -> distance=4, busy falls the same cycle, no further shifts. The next tick with run=1 scrolls a fresh 10.
6. Clear and saturation: force distance near 16'hFFFF via long runs (or a bench preload), scroll 20 pixels -> distance holds at 16'hFFFF. Assert clear mid-burst -> next cycle px_ground=0, distance=0, busy=0.
